// File: rtl/spi_master_ctrl.sv
// SPI master that issues the slave RAM commands (wr-addr, wr-data, rd-addr, rd-data) at one bit per clk.
// Optional macro SPI_MASTER_SEQ_CHECK_EN rejects rd-data frames that no completed rd-addr frame precedes.
module spi_master_ctrl #(
  parameter int RD_LATENCY = 2,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int FRAME_W = DATA_W + 3;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int WAIT_W  = $clog2(RD_LATENCY + 1);

  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_WAIT_RD = 3'd2,
    S_RECV    = 3'd3,
    S_TAIL    = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [FRAME_W-1:0]  r_frame, w_frame_nxt;
  logic [1:0]          r_cmd, w_cmd_nxt;
  logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt, w_bit_dec;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic [DATA_W-1:0]   r_rd_data, w_rd_data_nxt;
  logic                r_ss_n, w_ss_n_nxt;
  logic                r_mosi, w_mosi_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_rd_valid, w_rd_valid_nxt;
  logic                r_err, w_err_nxt;

  logic w_start_ok, w_accept, w_reject;
  logic w_is_rd, w_bit_last, w_wait_last;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic r_addr_ok;

  assign w_start_ok = (cmd != CMD_RD_DATA) || r_addr_ok;

  // Only completed frames move the flag; an aborted frame leaves it to reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_ok <= 1'b0;
    end else if (r_state == S_TAIL) begin
      if (r_cmd == CMD_RD_ADDR)      r_addr_ok <= 1'b1;
      else if (r_cmd == CMD_RD_DATA) r_addr_ok <= 1'b0;
    end
  end
`else
  assign w_start_ok = 1'b1;
`endif

  assign w_accept    = (r_state == S_IDLE) && start && w_start_ok;
  assign w_reject    = (r_state == S_IDLE) && start && !w_start_ok;
  assign w_is_rd     = (r_cmd == CMD_RD_DATA);
  assign w_bit_last  = (r_bit_cnt == '0);
  assign w_bit_dec   = r_bit_cnt - CNT_W'(1);
  assign w_wait_last = (r_wait_cnt == WAIT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept)    w_state_nxt = S_SHIFT;
      S_SHIFT:   if (w_bit_last)  w_state_nxt = w_is_rd ? S_WAIT_RD : S_TAIL;
      S_WAIT_RD: if (w_wait_last) w_state_nxt = S_RECV;
      S_RECV:    if (w_bit_last)  w_state_nxt = S_TAIL;
      S_TAIL:                     w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_frame_nxt    = r_frame;
    w_cmd_nxt      = r_cmd;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    w_shift_nxt    = r_shift;
    w_rd_data_nxt  = r_rd_data;
    w_ss_n_nxt     = r_ss_n;
    w_mosi_nxt     = r_mosi;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_rd_valid_nxt = 1'b0;
    w_err_nxt      = w_reject;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_frame_nxt   = {cmd[1], cmd, din};
          w_cmd_nxt     = cmd;
          w_ss_n_nxt    = 1'b0;
          w_mosi_nxt    = cmd[1];
          w_busy_nxt    = 1'b1;
          w_bit_cnt_nxt = CNT_W'(FRAME_W - 1);
        end
      end
      S_SHIFT: begin
        if (w_bit_last) begin
          w_mosi_nxt     = 1'b0;
          w_wait_cnt_nxt = WAIT_W'(RD_LATENCY);
        end else begin
          w_bit_cnt_nxt = w_bit_dec;
          w_mosi_nxt    = r_frame[w_bit_dec];
        end
      end
      // The wait spans RD_LATENCY cycles so the first sample lands on the slave's first data bit.
      S_WAIT_RD: begin
        w_wait_cnt_nxt = r_wait_cnt - WAIT_W'(1);
        if (w_wait_last) w_bit_cnt_nxt = CNT_W'(DATA_W - 1);
      end
      S_RECV: begin
        w_shift_nxt = {r_shift[DATA_W-2:0], MISO};
        if (!w_bit_last) w_bit_cnt_nxt = w_bit_dec;
      end
      S_TAIL: begin
        w_ss_n_nxt = 1'b1;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
        if (w_is_rd) begin
          w_rd_valid_nxt = 1'b1;
          w_rd_data_nxt  = r_shift;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame    <= '0;
      r_cmd      <= '0;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      r_shift    <= '0;
      r_rd_data  <= '0;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_frame    <= w_frame_nxt;
      r_cmd      <= w_cmd_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_ss_n     <= w_ss_n_nxt;
      r_mosi     <= w_mosi_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign err      = r_err;
  assign SS_n     = r_ss_n;
  assign MOSI     = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a behavioural SPI slave + RAM on the pins and a command-level RAM model
// supplying expected read data. Build with SPI_MASTER_SEQ_CHECK_EN to also cover the sequence check.
module tb_spi_master_ctrl;

  localparam int DATA_W     = 8;
  localparam int RD_LATENCY = 2;
  localparam int FRAME_W    = DATA_W + 3;
  localparam int WR_LEN     = DATA_W + 4;
  localparam int RD_LEN     = 2 * DATA_W + RD_LATENCY + 4;
  localparam int MEM_D      = 1 << DATA_W;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        cmd   = 2'b00;
  logic [DATA_W-1:0] din   = '0;
  logic              MISO  = 1'b0;
  logic              busy, done, rd_valid, err, SS_n, MOSI;
  logic [DATA_W-1:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  spi_master_ctrl #(.RD_LATENCY(RD_LATENCY), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .din(din),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .err(err),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Command-level reference: what the RAM should hold given the commands issued.
  logic [DATA_W-1:0] m_mem [MEM_D];
  logic [DATA_W-1:0] m_wr_addr = '0;
  logic [DATA_W-1:0] m_rd_addr = '0;
  logic [DATA_W-1:0] m_rd_data = '0;
  bit                m_addr_ok = 1'b0;

  // Pin-level slave: shifts in the frame word while SS_n is low, applies it to its RAM after the
  // last bit, and returns read data MSB first starting RD_LATENCY cycles after that last bit.
  logic [DATA_W-1:0]  s_ram [MEM_D];
  logic [DATA_W-1:0]  s_wr_addr = '0;
  logic [DATA_W-1:0]  s_rd_addr = '0;
  logic [DATA_W-1:0]  s_resp    = '0;
  logic [FRAME_W-1:0] s_word    = '0;
  logic [FRAME_W-1:0] s_last_word = '0;
  int s_cyc = 0, s_hi = 100, s_last_len = 0, s_last_gap = 0, s_frames = 0;
  bit s_resp_on = 1'b0, s_tail_bad = 1'b0;

  always @(negedge clk) begin : slave_model
    int c;
    c = s_cyc;
    if (SS_n === 1'b0) begin
      if (c == 0) begin
        s_last_gap = s_hi;
        s_tail_bad = 1'b0;
        s_resp_on  = 1'b0;
      end
      s_hi = 0;
      if (c < FRAME_W) begin
        s_word = {s_word[FRAME_W-2:0], MOSI};
        if (c == FRAME_W - 1) begin
          case (s_word[FRAME_W-1 -: 3])
            3'b000: s_wr_addr = s_word[DATA_W-1:0];
            3'b001: s_ram[s_wr_addr] = s_word[DATA_W-1:0];
            3'b110: s_rd_addr = s_word[DATA_W-1:0];
            3'b111: begin s_resp = s_ram[s_rd_addr]; s_resp_on = 1'b1; end
            default: ;
          endcase
        end
      end else if (MOSI !== 1'b0) begin
        s_tail_bad = 1'b1;
      end
      s_cyc = c + 1;
    end else begin
      if (c != 0) begin
        s_last_len  = c;
        s_last_word = s_word;
        s_frames++;
      end
      s_cyc = 0;
      s_hi++;
    end
    if (SS_n === 1'b0 && s_resp_on && c >= FRAME_W + RD_LATENCY && c < FRAME_W + RD_LATENCY + DATA_W)
      MISO = s_resp[DATA_W - 1 - (c - FRAME_W - RD_LATENCY)];
    else
      MISO = 1'($urandom);
  end

  task automatic do_frame(input logic [1:0] c, input logic [DATA_W-1:0] d);
    bit rej, got;
    int frames0, exp_len;
    logic [DATA_W-1:0]  exp_rd;
    logic [FRAME_W-1:0] exp_word;
    rej = 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    rej = (c == 2'b11) && !m_addr_ok;
`endif
    exp_word = {c[1], c, d};
    exp_len  = (c == 2'b11) ? RD_LEN : WR_LEN;
    exp_rd   = m_mem[m_rd_addr];
    frames0  = s_frames;
    @(negedge clk); start = 1'b1; cmd = c; din = d;
    @(negedge clk); start = 1'b0; cmd = 2'($urandom); din = DATA_W'($urandom);
    if (rej) begin
      n_checks++;
      if ({err, busy, SS_n} !== 3'b101) begin
        n_errors++; $display("FAIL reject_pulse cmd=%b: {err,busy,SS_n} got %b expected 101", c, {err, busy, SS_n});
      end
      repeat (4) begin
        @(negedge clk);
        n_checks++;
        if ({err, busy, done, SS_n} !== 4'b0001) begin
          n_errors++; $display("FAIL reject_idle: {err,busy,done,SS_n} got %b expected 0001", {err, busy, done, SS_n});
        end
      end
      n_checks++;
      if (s_frames !== frames0) begin
        n_errors++; $display("FAIL reject_no_frame: frames got %0d expected %0d", s_frames, frames0);
      end
      return;
    end
    n_checks++;
    if ({busy, SS_n, err} !== 3'b100) begin
      n_errors++; $display("FAIL accept cmd=%b: {busy,SS_n,err} got %b expected 100", c, {busy, SS_n, err});
    end
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        n_checks++;
        if (rd_data !== m_rd_data || rd_valid !== 1'b0 || err !== 1'b0) begin
          n_errors++; $display("FAIL in_frame t=%0d: rd_data=%h rd_valid=%b err=%b expected %h 0 0", t, rd_data, rd_valid, err, m_rd_data);
        end
      end
    end
    n_checks++;
    if (!got) begin
      n_errors++; $display("FAIL done_timeout cmd=%b: no done within 100 cycles", c);
      return;
    end
    if (c == 2'b11) m_rd_data = exp_rd;
    n_checks++;
    if ({SS_n, busy, rd_valid} !== {1'b1, 1'b0, c == 2'b11} || rd_data !== m_rd_data) begin
      n_errors++; $display("FAIL done_cycle cmd=%b: {SS_n,busy,rd_valid}=%b rd_data=%h expected %b %h",
                           c, {SS_n, busy, rd_valid}, rd_data, {1'b1, 1'b0, c == 2'b11}, m_rd_data);
    end
    case (c)
      2'b00: m_wr_addr = d;
      2'b01: m_mem[m_wr_addr] = d;
      2'b10: begin m_rd_addr = d; m_addr_ok = 1'b1; end
      default: m_addr_ok = 1'b0;
    endcase
    @(negedge clk); #1;
    n_checks++;
    if ({done, rd_valid} !== 2'b00) begin
      n_errors++; $display("FAIL pulse_width: {done,rd_valid} got %b expected 00", {done, rd_valid});
    end
    n_checks++;
    if (s_last_word !== exp_word || s_last_len != exp_len || s_tail_bad) begin
      n_errors++; $display("FAIL frame_shape cmd=%b: word %h len %0d tail_bad %0d expected %h %0d 0",
                           c, s_last_word, s_last_len, s_tail_bad, exp_word, exp_len);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; cmd = 2'b11; din = DATA_W'($urandom);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({SS_n, MOSI, busy, done, rd_valid, err} !== 6'b100000 || rd_data !== '0) begin
      n_errors++; $display("FAIL reset_state: {SS_n,MOSI,busy,done,rd_valid,err}=%b rd_data=%h expected 100000 0",
                           {SS_n, MOSI, busy, done, rd_valid, err}, rd_data);
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({SS_n, busy, err} !== 3'b100) begin
      n_errors++; $display("FAIL reset_release: {SS_n,busy,err} got %b expected 100", {SS_n, busy, err});
    end
    m_rd_data = '0; m_addr_ok = 1'b0;
  endtask

`ifdef SPI_MASTER_SEQ_CHECK_EN
  task automatic test_seq_check;
    do_frame(2'b11, DATA_W'($urandom));
    do_frame(2'b10, DATA_W'($urandom));
    do_frame(2'b11, DATA_W'($urandom));
    do_frame(2'b11, DATA_W'($urandom));
  endtask
`endif

  task automatic test_write_addr;
    do_frame(2'b00, '1);
    n_checks++;
    if (s_wr_addr !== '1) begin
      n_errors++; $display("FAIL write_addr: slave address got %h expected %h", s_wr_addr, {DATA_W{1'b1}});
    end
  endtask

  task automatic test_write_read;
    do_frame(2'b01, DATA_W'(8'hA5));
    do_frame(2'b10, '1);
    do_frame(2'b11, DATA_W'($urandom));
    n_checks++;
    if (rd_data !== DATA_W'(8'hA5)) begin
      n_errors++; $display("FAIL readback: rd_data got %h expected a5", rd_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] d1, d2;
    bit got;
    d1 = DATA_W'($urandom); d2 = DATA_W'($urandom);
    @(negedge clk); start = 1'b1; cmd = 2'b00; din = d1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin n_errors++; $display("FAIL b2b_first_done: timeout"); end
    cmd = 2'b01; din = d2;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if ({busy, SS_n} !== 2'b10) begin
      n_errors++; $display("FAIL b2b_accept: {busy,SS_n} got %b expected 10", {busy, SS_n});
    end
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin n_errors++; $display("FAIL b2b_second_done: timeout"); end
    m_wr_addr = d1; m_mem[d1] = d2;
    @(negedge clk); #1;
    n_checks++;
    if (s_last_gap != 1 || s_last_word !== {1'b0, 2'b01, d2} || s_last_len != WR_LEN) begin
      n_errors++; $display("FAIL b2b_frame: gap %0d word %h len %0d expected 1 %h %0d",
                           s_last_gap, s_last_word, s_last_len, {1'b0, 2'b01, d2}, WR_LEN);
    end
    n_checks++;
    if (s_wr_addr !== d1 || s_ram[d1] !== d2) begin
      n_errors++; $display("FAIL b2b_ram: addr %h data %h expected %h %h", s_wr_addr, s_ram[d1], d1, d2);
    end
  endtask

  task automatic test_mid_reset;
    logic [DATA_W-1:0] a;
    bit saw_done;
    a = DATA_W'($urandom);
    do_frame(2'b10, a);
    @(negedge clk); start = 1'b1; cmd = 2'b11;
    @(negedge clk); start = 1'b0;
    repeat (FRAME_W + RD_LATENCY + 3) @(negedge clk);
    n_checks++;
    if ({SS_n, busy} !== 2'b01 || rd_data !== m_rd_data) begin
      n_errors++; $display("FAIL mid_recv: {SS_n,busy}=%b rd_data=%h expected 01 %h", {SS_n, busy}, rd_data, m_rd_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({SS_n, MOSI, busy, done, rd_valid} !== 5'b10000 || rd_data !== '0) begin
      n_errors++; $display("FAIL mid_reset: {SS_n,MOSI,busy,done,rd_valid}=%b rd_data=%h expected 10000 0",
                           {SS_n, MOSI, busy, done, rd_valid}, rd_data);
    end
    @(negedge clk); rst_n = 1'b1;
    m_rd_data = '0; m_addr_ok = 1'b0;
    saw_done = 1'b0;
    repeat (RD_LEN + 4) begin
      @(negedge clk);
      if (done === 1'b1 || rd_valid === 1'b1 || SS_n !== 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin n_errors++; $display("FAIL mid_abort: activity after reset got 1 expected 0"); end
    do_frame(2'b10, a);
    do_frame(2'b11, DATA_W'($urandom));
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++)
      do_frame(2'($urandom_range(0, 3)), DATA_W'($urandom_range(0, 7)));
  endtask

  initial begin
    for (int i = 0; i < MEM_D; i++) begin
      m_mem[i] = '0;
      s_ram[i] = '0;
    end
    test_reset();
`ifdef SPI_MASTER_SEQ_CHECK_EN
    test_seq_check();
`endif
    test_write_addr();
    test_write_read();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
